btn_conditioner: RTL and testbench

Per-button input conditioner between the board push-buttons (already inverted to active-high) and the `btn` input of the CPU `top`. Each bit is synchronised, debounced by a stable-count filter, and turned into a clean level, one-cycle press/release strobes and an auto-repeat strobe for held buttons. Bits are fully independent. All logic runs on the 50 MHz board clock.

---
 rtl/btn_conditioner_if.sv | 43 ++++
 rtl/btn_conditioner.sv | 171 +++++++++++++++++
 tb/tb_btn_conditioner.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/btn_conditioner_if.sv
// ----------------------------------------------------------------------------
// btn_conditioner_if
//
// Groups the raw button inputs with the conditioned outputs of
// btn_conditioner. Every vector is WIDTH bits, one bit per button.
//
//   btn_raw     : raw active-high buttons, asynchronous to the system clock
//   btn_level   : debounced level
//   btn_press   : one-cycle strobe on a debounced 0->1
//   btn_release : one-cycle strobe on a debounced 1->0
//   btn_repeat  : one-cycle strobe on press, then auto-repeat while held
//
// Modports:
//   master : the board/bench side, drives btn_raw and reads the results
//   slave  : the conditioner, reads btn_raw and drives the results
// ----------------------------------------------------------------------------
interface btn_conditioner_if #(
   parameter int WIDTH = 3
);

   logic [WIDTH-1:0] btn_raw;
   logic [WIDTH-1:0] btn_level;
   logic [WIDTH-1:0] btn_press;
   logic [WIDTH-1:0] btn_release;
   logic [WIDTH-1:0] btn_repeat;

   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_press,
      input  btn_release,
      input  btn_repeat
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_press,
      output btn_release,
      output btn_repeat
   );

endinterface

// File: rtl/btn_conditioner.sv
// ----------------------------------------------------------------------------
// btn_conditioner
//
// Per-button conditioner for the board push-buttons. Each bit is
// synchronised by a two-flop chain, debounced by a stable-count filter and
// turned into a clean level, one-cycle press/release strobes and an
// auto-repeat strobe. Bits are fully independent of each other.
//
// Parameters:
//   WIDTH           : number of buttons
//   DEBOUNCE_CYCLES : cycles a new synchronised value must persist (>=1)
//   REPEAT_DELAY    : cycles from the press strobe to the first repeat (>=1)
//   REPEAT_RATE     : cycles between later repeat strobes (>=1)
//
// Ports:
//   clk    : system clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset, clears every flop
//   btn_if : slave side of btn_conditioner_if (raw in, conditioned out)
//
// All outputs come straight from flops; there is no combinational path from
// btn_raw to any output.
// ----------------------------------------------------------------------------
module btn_conditioner #(
   parameter int WIDTH           = 3,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_RATE     = 5_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   btn_conditioner_if.slave     btn_if
);

   localparam int CW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int T_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [CW-1:0] CNT_TERM   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] DELAY_TERM = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] RATE_TERM  = TW'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_REPEAT
   } rep_state_e;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit

      logic             s1;
      logic             s2;
      logic [CW-1:0]    cnt;
      logic             level;
      logic             press_q;
      logic             release_q;
      logic             repeat_q;
      logic             accept;
      logic             press_evt;
      logic             release_evt;
      rep_state_e       state;
      rep_state_e       state_next;
      logic [TW-1:0]    timer;
      logic [TW-1:0]    timer_next;
      logic             repeat_next;

      // A new synchronised value is accepted once it has disagreed with the
      // debounced level for DEBOUNCE_CYCLES consecutive cycles.
      assign accept      = (s2 != level) && (cnt == CNT_TERM);
      assign press_evt   = accept & s2;
      assign release_evt = accept & ~s2;

      // Synchroniser plus stable-count filter. Any cycle where s2 agrees with
      // the level clears the count, so short glitches never get through.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            cnt       <= '0;
            level     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            s1        <= btn_if.btn_raw[i];
            s2        <= s1;
            press_q   <= press_evt;
            release_q <= release_evt;
            if (s2 == level) begin
               cnt <= '0;
            end else if (cnt == CNT_TERM) begin
               level <= s2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end

      // Repeat FSM state register; the repeat strobe and timer are registered
      // here too so btn_repeat lines up with btn_press.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state    <= ST_IDLE;
            timer    <= '0;
            repeat_q <= 1'b0;
         end else begin
            state    <= state_next;
            timer    <= timer_next;
            repeat_q <= repeat_next;
         end
      end

      // Next-state logic. A release always wins over a terminal count.
      always_comb begin
         state_next = state;
         case (state)
            ST_IDLE: begin
               if (press_evt) state_next = ST_DELAY;
            end
            ST_DELAY: begin
               if (release_evt)              state_next = ST_IDLE;
               else if (timer == DELAY_TERM) state_next = ST_REPEAT;
            end
            ST_REPEAT: begin
               if (release_evt) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end

      // Timer and repeat strobe. Terminal counts reload zero, so the timer
      // never wraps regardless of its width.
      always_comb begin
         timer_next  = timer;
         repeat_next = 1'b0;
         case (state)
            ST_IDLE: begin
               timer_next  = '0;
               repeat_next = press_evt;
            end
            ST_DELAY: begin
               if (release_evt) begin
                  timer_next = '0;
               end else if (timer == DELAY_TERM) begin
                  timer_next  = '0;
                  repeat_next = 1'b1;
               end else begin
                  timer_next = timer + TW'(1);
               end
            end
            ST_REPEAT: begin
               if (release_evt) begin
                  timer_next = '0;
               end else if (timer == RATE_TERM) begin
                  timer_next  = '0;
                  repeat_next = 1'b1;
               end else begin
                  timer_next = timer + TW'(1);
               end
            end
            default: timer_next = '0;
         endcase
      end

      assign btn_if.btn_level[i]   = level;
      assign btn_if.btn_press[i]   = press_q;
      assign btn_if.btn_release[i] = release_q;
      assign btn_if.btn_repeat[i]  = repeat_q;

   end

endmodule

// File: tb/tb_btn_conditioner.sv
// ----------------------------------------------------------------------------
// tb_btn_conditioner
//
// Directed bench for btn_conditioner with short debounce/repeat constants.
// Each test states when presses and releases should be accepted; the
// expected outputs for every cycle follow from those times and the repeat
// schedule (P, P+REPEAT_DELAY, then every REPEAT_RATE until the release).
// Expected samples are queued as stimulus is driven and popped as the DUT
// output for that cycle is sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_btn_conditioner;

   localparam int WIDTH           = 3;
   localparam int DEBOUNCE_CYCLES = 4;
   localparam int REPEAT_DELAY    = 10;
   localparam int REPEAT_RATE     = 3;
   localparam int LATENCY         = DEBOUNCE_CYCLES + 1;
   localparam int NONE            = 1_000_000;

   typedef struct packed {
      logic [WIDTH-1:0] level;
      logic [WIDTH-1:0] press;
      logic [WIDTH-1:0] rel;
      logic [WIDTH-1:0] rep;
   } exp_t;

   logic clk;
   logic rst_n;

   btn_conditioner_if #(.WIDTH(WIDTH)) bif ();

   btn_conditioner #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_if (bif)
   );

   // 10-unit clock period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   sample_no   = 0;
   bit   in_reset    = 1'b0;
   int   p_at[WIDTH];
   int   r_at[WIDTH];

   // Expected outputs for sample n from the scheduled accept times.
   function automatic exp_t exp_at(int n);
      exp_t e;
      e = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (n >= p_at[i] && n < r_at[i]) begin
            e.level[i] = 1'b1;
            if (n == p_at[i]) e.press[i] = 1'b1;
            if (n == p_at[i] ||
                (n - p_at[i] >= REPEAT_DELAY &&
                 (n - p_at[i] - REPEAT_DELAY) % REPEAT_RATE == 0))
               e.rep[i] = 1'b1;
         end
         if (n == r_at[i]) e.rel[i] = 1'b1;
      end
      return e;
   endfunction

   function automatic void clearSchedule();
      for (int i = 0; i < WIDTH; i++) begin
         p_at[i] = NONE;
         r_at[i] = NONE;
      end
   endfunction

   function automatic void schedPress(int b, int n);
      p_at[b] = n;
      r_at[b] = NONE;
   endfunction

   function automatic void schedRelease(int b, int n);
      r_at[b] = n;
   endfunction

   task automatic compareField(input string tag, input logic [WIDTH-1:0] obs,
                               input logic [WIDTH-1:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("[TB] FAIL %s sample %0d: observed %b expected %b", tag, sample_no, obs, expv);
      end
   endtask

   // Drive the raw buttons for the next rising edge and queue what the DUT
   // should show after that edge.
   task automatic applyStimulus(input logic [WIDTH-1:0] raw);
      bif.btn_raw = raw;
      if (in_reset) exp_q.push_back('0);
      else          exp_q.push_back(exp_at(sample_no));
   endtask

   // Sample after the falling edge and compare against the queue head.
   task automatic checkOutput();
      exp_t e;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL scoreboard sample %0d: observed empty queue expected an entry", sample_no);
      end else begin
         e = exp_q.pop_front();
         compareField("level",   bif.btn_level,   e.level);
         compareField("press",   bif.btn_press,   e.press);
         compareField("release", bif.btn_release, e.rel);
         compareField("repeat",  bif.btn_repeat,  e.rep);
      end
      sample_no++;
   endtask

   task automatic runCycles(input logic [WIDTH-1:0] raw, input int n);
      for (int k = 0; k < n; k++) begin
         applyStimulus(raw);
         @(posedge clk);
         @(negedge clk);
         checkOutput();
      end
   endtask

   initial begin
      int s;
      rst_n       = 1'b0;
      bif.btn_raw = '0;
      clearSchedule();
      @(negedge clk);

      // Reset with all buttons held, then release of reset gives a press.
      $display("[TB] reset with buttons held");
      in_reset = 1'b1;
      runCycles(3'b111, 20);
      rst_n    = 1'b1;
      in_reset = 1'b0;
      for (int i = 0; i < WIDTH; i++) schedPress(i, sample_no + LATENCY);
      runCycles(3'b111, 8);
      for (int i = 0; i < WIDTH; i++) schedRelease(i, sample_no + LATENCY);
      runCycles(3'b000, 10);

      // Clean press and release of bit 0.
      $display("[TB] clean press bit 0");
      schedPress(0, sample_no + LATENCY);
      runCycles(3'b001, 8);
      schedRelease(0, sample_no + LATENCY);
      runCycles(3'b000, 10);

      // Bounce on bit 1: 3 high / 2 low never reaches the debounce count.
      $display("[TB] bounce bit 1");
      for (int k = 0; k < 10; k++) begin
         runCycles(3'b010, 3);
         runCycles(3'b000, 2);
      end
      runCycles(3'b000, 8);

      // Auto-repeat on bit 2, released so the last repeat is P+16.
      $display("[TB] auto-repeat bit 2");
      s = sample_no;
      schedPress(2, s + LATENCY);
      runCycles(3'b100, 18);
      schedRelease(2, sample_no + LATENCY);
      runCycles(3'b000, 12);

      // Release accepted exactly when the repeat timer is at its terminal count.
      $display("[TB] release racing a repeat");
      s = sample_no;
      schedPress(2, s + LATENCY);
      runCycles(3'b100, 13);
      schedRelease(2, sample_no + LATENCY);
      runCycles(3'b000, 12);

      // Asynchronous reset in the middle of a held press.
      $display("[TB] reset mid-hold bit 0");
      schedPress(0, sample_no + LATENCY);
      runCycles(3'b001, 8);
      #2;
      rst_n = 1'b0;
      #1;
      compareField("async_level",   bif.btn_level,   3'b000);
      compareField("async_press",   bif.btn_press,   3'b000);
      compareField("async_release", bif.btn_release, 3'b000);
      compareField("async_repeat",  bif.btn_repeat,  3'b000);
      exp_q.delete();
      in_reset = 1'b1;
      runCycles(3'b001, 3);
      rst_n    = 1'b1;
      in_reset = 1'b0;
      clearSchedule();
      schedPress(0, sample_no + LATENCY);
      runCycles(3'b001, 12);
      schedRelease(0, sample_no + LATENCY);
      runCycles(3'b000, 10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
